// File: rtl/vga_sprite_multi_core_pkg.sv
// Shared register map and types for the multi-sprite overlay core.
package vga_sprite_pkg;

  localparam logic [2:0] REG_EN     = 3'd0;
  localparam logic [2:0] REG_X0     = 3'd1;
  localparam logic [2:0] REG_Y0     = 3'd2;
  localparam logic [2:0] REG_BYPASS = 3'd3;
  localparam logic [2:0] REG_KEY    = 3'd4;

  localparam logic [31:0] KEY_DEFAULT = 32'h0000_0000;

  typedef logic [10:0] sprite_pos_t;

endpackage

// File: rtl/vga_sprite_multi_core_slice.sv
// One sprite: region compare, pixel address, sync sprite RAM and the
// registered in-region flag that qualifies the RAM read data.
module sprite_gen_slice
  import vga_sprite_pkg::*;
#(
  parameter int CD       = 12,
  parameter int SPR_ADDR = 10,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  sprite_pos_t         x,
  input  sprite_pos_t         y,
  input  logic                act_en,
  input  sprite_pos_t         act_x0,
  input  sprite_pos_t         act_y0,
  input  logic [CD-1:0]       key,
  input  logic                we,
  input  logic [SPR_ADDR-1:0] waddr,
  input  logic [CD-1:0]       wdata,
  output logic [CD-1:0]       pix,
  output logic                opaque
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);

  sprite_pos_t         dx;
  sprite_pos_t         dy;
  logic                in_region_d;
  logic                in_region_q;
  logic [SPR_ADDR-1:0] raddr;
  logic [CD-1:0]       ram [2**SPR_ADDR];
  logic [CD-1:0]       rdata_q;

  // Positions left of / above the origin wrap to large dx/dy and fall out of range.
  always_comb begin
    dx          = x - act_x0;
    dy          = y - act_y0;
    in_region_d = act_en && (dx < sprite_pos_t'(SPR_W)) && (dy < sprite_pos_t'(SPR_H));
    raddr       = SPR_ADDR'({dy[YB-1:0], dx[XB-1:0]});
  end

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    rdata_q <= ram[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) in_region_q <= 1'b0;
    else       in_region_q <= in_region_d;
  end

  assign pix    = rdata_q;
  assign opaque = in_region_q && (rdata_q != key);

endmodule

// File: rtl/vga_sprite_multi_core.sv
// Multi-sprite chroma-key overlay with frame-synchronous position commit
// and a fixed two-cycle pipeline from x/y/si_rgb to so_rgb.
module vga_sprite_multi_core
  import vga_sprite_pkg::*;
#(
  parameter int CD       = 12,
  parameter int NUM_SPR  = 4,
  parameter int SPR_ADDR = 10,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  logic                wr_en;
  logic [2:0]          reg_sel;
  logic [2:0]          reg_idx;
  logic [3:0]          ram_sel;
  logic [NUM_SPR-1:0]  ram_we;
  logic                at_origin;
  logic                frame_start;
  logic                frame_prev_d, frame_prev_q;

  logic [NUM_SPR-1:0]  pend_en_d, pend_en_q, act_en_d, act_en_q;
  sprite_pos_t         pend_x0_d [NUM_SPR];
  sprite_pos_t         pend_x0_q [NUM_SPR];
  sprite_pos_t         pend_y0_d [NUM_SPR];
  sprite_pos_t         pend_y0_q [NUM_SPR];
  sprite_pos_t         act_x0_d  [NUM_SPR];
  sprite_pos_t         act_x0_q  [NUM_SPR];
  sprite_pos_t         act_y0_d  [NUM_SPR];
  sprite_pos_t         act_y0_q  [NUM_SPR];
  logic                bypass_d, bypass_q;
  logic [CD-1:0]       key_d, key_q;
  logic [CD-1:0]       si_d1_d, si_d1_q;
  logic [CD-1:0]       so_rgb_d, so_rgb_q;

  logic [CD-1:0]       spr_pix [NUM_SPR];
  logic [NUM_SPR-1:0]  spr_opaque;
  logic                unused_bits;

  assign unused_bits = ^{wr_data, addr};

  always_comb begin
    wr_en   = cs & write;
    reg_sel = addr[2:0];
    reg_idx = addr[5:3];
    ram_sel = (NUM_SPR > 1) ? 4'(addr[SPR_ADDR +: SW]) : 4'd0;
    for (int s = 0; s < NUM_SPR; s++) begin
      ram_we[s] = wr_en && !addr[13] && (ram_sel == 4'(s));
    end
  end

  always_comb begin
    at_origin    = (x == 11'd0) && (y == 11'd0);
    frame_start  = at_origin && !frame_prev_q;
    frame_prev_d = at_origin;

    pend_en_d = pend_en_q;
    pend_x0_d = pend_x0_q;
    pend_y0_d = pend_y0_q;
    bypass_d  = bypass_q;
    key_d     = key_q;

    if (wr_en && addr[13]) begin
      case (reg_sel)
        REG_BYPASS: bypass_d = wr_data[0];
        REG_KEY:    key_d    = wr_data[CD-1:0];
        default:    ;
      endcase
      for (int s = 0; s < NUM_SPR; s++) begin
        if (reg_idx == 3'(s)) begin
          case (reg_sel)
            REG_EN:  pend_en_d[s] = wr_data[0];
            REG_X0:  pend_x0_d[s] = wr_data[10:0];
            REG_Y0:  pend_y0_d[s] = wr_data[10:0];
            default: ;
          endcase
        end
      end
    end

    // Commit samples the registered pending set, so a same-cycle write waits a frame.
    act_en_d = act_en_q;
    act_x0_d = act_x0_q;
    act_y0_d = act_y0_q;
    if (frame_start) begin
      act_en_d = pend_en_q;
      act_x0_d = pend_x0_q;
      act_y0_d = pend_y0_q;
    end
  end

  for (genvar s = 0; s < NUM_SPR; s++) begin : g_spr
    sprite_gen_slice #(
      .CD       (CD),
      .SPR_ADDR (SPR_ADDR),
      .SPR_W    (SPR_W),
      .SPR_H    (SPR_H)
    ) u_slice (
      .clk    (clk),
      .reset  (reset),
      .x      (x),
      .y      (y),
      .act_en (act_en_q[s]),
      .act_x0 (act_x0_q[s]),
      .act_y0 (act_y0_q[s]),
      .key    (key_q),
      .we     (ram_we[s]),
      .waddr  (addr[SPR_ADDR-1:0]),
      .wdata  (wr_data[CD-1:0]),
      .pix    (spr_pix[s]),
      .opaque (spr_opaque[s])
    );
  end

  // Descending scan so the lowest-index opaque sprite wins.
  always_comb begin
    si_d1_d  = si_rgb;
    so_rgb_d = si_d1_q;
    if (!bypass_q) begin
      for (int s = NUM_SPR - 1; s >= 0; s--) begin
        if (spr_opaque[s]) so_rgb_d = spr_pix[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_prev_q <= 1'b1;
      pend_en_q    <= '0;
      act_en_q     <= '0;
      pend_x0_q    <= '{default: '0};
      pend_y0_q    <= '{default: '0};
      act_x0_q     <= '{default: '0};
      act_y0_q     <= '{default: '0};
      bypass_q     <= 1'b0;
      key_q        <= CD'(KEY_DEFAULT);
      si_d1_q      <= '0;
      so_rgb_q     <= '0;
    end else begin
      frame_prev_q <= frame_prev_d;
      pend_en_q    <= pend_en_d;
      act_en_q     <= act_en_d;
      pend_x0_q    <= pend_x0_d;
      pend_y0_q    <= pend_y0_d;
      act_x0_q     <= act_x0_d;
      act_y0_q     <= act_y0_d;
      bypass_q     <= bypass_d;
      key_q        <= key_d;
      si_d1_q      <= si_d1_d;
      so_rgb_q     <= so_rgb_d;
    end
  end

  assign so_rgb = so_rgb_q;

endmodule

// File: tb/tb_vga_sprite_multi_core.sv
// Randomised bench for vga_sprite_multi_core against a behavioural overlay model.
module tb_vga_sprite_multi_core;

  localparam int CD      = 12;
  localparam int NUM_SPR = 4;
  localparam int SPR_W   = 32;
  localparam int SPR_H   = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x, y;
  logic          cs, write;
  logic [13:0]   addr;
  logic [31:0]   wr_data;
  logic [CD-1:0] si_rgb, so_rgb;

  always #5 clk = ~clk;

  vga_sprite_multi_core #(
    .CD(CD), .NUM_SPR(NUM_SPR), .SPR_ADDR(10), .SPR_W(SPR_W), .SPR_H(SPR_H)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "init";

  task automatic check_eq(input string tag, input logic [CD-1:0] got, input logic [CD-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: so_rgb=%h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model state: what software has programmed and what the current frame uses.
  logic [CD-1:0] m_ram [NUM_SPR][1024];
  bit            m_pend_en [NUM_SPR];
  bit            m_act_en  [NUM_SPR];
  int            m_pend_x  [NUM_SPR];
  int            m_pend_y  [NUM_SPR];
  int            m_act_x   [NUM_SPR];
  int            m_act_y   [NUM_SPR];
  logic [CD-1:0] m_key;
  bit            m_bypass;
  bit            m_prev_origin;

  // What each sprite contributes to one pixel, resolved one cycle later.
  typedef struct packed {
    logic                         known;
    logic [CD-1:0]                si;
    logic [NUM_SPR-1:0]           hit;
    logic [NUM_SPR-1:0][CD-1:0]   pix;
  } rec_t;

  rec_t          rec1;
  logic [CD-1:0] exp_so;
  bit            exp_known = 1'b0;

  function automatic logic [CD-1:0] resolve(input rec_t r, input logic [CD-1:0] k, input bit byp);
    if (byp) return r.si;
    for (int s = 0; s < NUM_SPR; s++)
      if (r.hit[s] && r.pix[s] != k) return r.pix[s];
    return r.si;
  endfunction

  function automatic logic [13:0] reg_addr(input int s, input int r);
    return {1'b1, 7'd0, 3'(s), 3'(r)};
  endfunction

  function automatic logic [13:0] ram_addr(input int s, input int p);
    return 14'((s << 10) | p);
  endfunction

  function automatic logic [CD-1:0] pal();
    case ($urandom_range(0, 4))
      0:       return 12'h000;
      1:       return 12'hF00;
      2:       return 12'h0F0;
      3:       return 12'h00F;
      default: return CD'($urandom);
    endcase
  endfunction

  task automatic cyc(input int cx, input int cy, input bit cw, input logic [13:0] ca,
                     input logic [31:0] cd, input bit crst);
    rec_t r;
    int   dx, dy, s, rg;
    bit   origin, fs;
    x = 11'(cx); y = 11'(cy); si_rgb = CD'($urandom); reset = crst;
    addr = ca; wr_data = cd;
    if (cw) begin
      cs = 1'b1; write = 1'b1;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin cs = 1'b0; write = 1'b0; end
        1:       begin cs = 1'b1; write = 1'b0; end
        default: begin cs = 1'b0; write = 1'b1; end
      endcase
    end
    @(negedge clk);
    if (exp_known) check_eq(phase, so_rgb, exp_so);
    if (crst) begin
      exp_so = '0; exp_known = 1'b1;
      rec1 = '0; rec1.known = 1'b1;
      m_prev_origin = 1'b1; m_key = '0; m_bypass = 1'b0;
      for (int i = 0; i < NUM_SPR; i++) begin
        m_pend_en[i] = 0; m_act_en[i] = 0;
        m_pend_x[i] = 0; m_pend_y[i] = 0; m_act_x[i] = 0; m_act_y[i] = 0;
      end
    end else begin
      exp_so    = resolve(rec1, m_key, m_bypass);
      exp_known = rec1.known;
      r = '0; r.known = 1'b1; r.si = si_rgb;
      for (int i = 0; i < NUM_SPR; i++) begin
        dx = (cx - m_act_x[i]) & 2047;
        dy = (cy - m_act_y[i]) & 2047;
        if (m_act_en[i] && dx < SPR_W && dy < SPR_H) begin
          r.hit[i] = 1'b1;
          r.pix[i] = m_ram[i][dy * SPR_W + dx];
        end
      end
      rec1 = r;
      origin = (cx == 0) && (cy == 0);
      fs = origin && !m_prev_origin;
      m_prev_origin = origin;
      if (fs) begin
        m_act_en = m_pend_en; m_act_x = m_pend_x; m_act_y = m_pend_y;
      end
      if (cw) begin
        if (!ca[13]) begin
          s = int'(ca[11:10]);
          if (s < NUM_SPR) m_ram[s][ca[9:0]] = cd[CD-1:0];
        end else begin
          rg = int'(ca[2:0]); s = int'(ca[5:3]);
          case (rg)
            0: if (s < NUM_SPR) m_pend_en[s] = cd[0];
            1: if (s < NUM_SPR) m_pend_x[s]  = int'(cd[10:0]);
            2: if (s < NUM_SPR) m_pend_y[s]  = int'(cd[10:0]);
            3: m_bypass = cd[0];
            4: m_key    = cd[CD-1:0];
            default: ;
          endcase
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    cyc(int'($urandom_range(1, 2047)), int'($urandom_range(0, 2047)), 1'b1, a, d, 1'b0);
  endtask

  // Raster over a window; optional single write at pixel index wr_at (0 = origin cycle).
  task automatic scan(input int x_lo, input int x_hi, input int y_lo, input int y_hi,
                      input bit with_origin, input int wr_at,
                      input logic [13:0] wa, input logic [31:0] wd);
    int k;
    k = 0;
    if (with_origin) cyc(0, 0, wr_at == 0, wa, wd, 1'b0);
    for (int yy = y_lo; yy <= y_hi; yy++)
      for (int xx = x_lo; xx <= x_hi; xx++) begin
        k++;
        cyc(xx, yy, wr_at == k, wa, wd, 1'b0);
      end
  endtask

  task automatic frame(input bit with_origin);
    scan(96, 135, 48, 83, with_origin, -1, 14'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; cs = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; si_rgb = '0;
    @(posedge clk); #1;

    phase = "reset";
    repeat (3) cyc(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b0, 14'd0, 32'd0, 1'b1);

    phase = "fill";
    for (int s = 0; s < NUM_SPR; s++)
      for (int p = 0; p < 1024; p++)
        cyc(int'($urandom_range(1, 2047)), int'($urandom_range(0, 2047)), 1'b1, ram_addr(s, p),
            (s == 0) ? 32'hF00 : (s == 1) ? 32'h0F0 : 32'($urandom), 1'b0);

    phase = "pre_commit";
    wr(reg_addr(0, 0), 32'd1); wr(reg_addr(0, 1), 32'd100); wr(reg_addr(0, 2), 32'd50);
    frame(1'b0);

    phase = "commit";
    frame(1'b1);

    phase = "priority";
    wr(reg_addr(1, 0), 32'd1); wr(reg_addr(1, 1), 32'd100); wr(reg_addr(1, 2), 32'd50);
    for (int p = 0; p < 640; p++) wr(ram_addr(0, p), (p < 320) ? 32'h000 : 32'h00F);
    frame(1'b1);

    phase = "key";
    wr(reg_addr(0, 4), 32'h00F);
    frame(1'b1);
    wr(reg_addr(0, 4), 32'h000);

    phase = "mid_write";
    scan(96, 135, 48, 83, 1'b1, 700, reg_addr(0, 1), 32'd200);
    frame(1'b1);

    phase = "commit_race";
    scan(96, 135, 48, 83, 1'b1, 0, reg_addr(0, 1), 32'd100);
    frame(1'b1);

    phase = "wrap";
    wr(reg_addr(2, 0), 32'd1); wr(reg_addr(2, 1), 32'd2040); wr(reg_addr(2, 2), 32'd60);
    wr(reg_addr(3, 0), 32'd1); wr(reg_addr(3, 1), 32'd10);   wr(reg_addr(3, 2), 32'd60);
    scan(0, 20, 56, 66, 1'b1, -1, 14'd0, 32'd0);

    phase = "bypass";
    wr(reg_addr(0, 3), 32'd1);
    frame(1'b1);
    wr(reg_addr(0, 3), 32'd0);

    phase = "random";
    for (int i = 0; i < 6000; i++) begin
      int cx, cy, sp, kind;
      logic [13:0] a;
      logic [31:0] d;
      bit w;
      if ($urandom_range(0, 99) < 2) begin
        cx = 0; cy = 0;
      end else begin
        sp = int'($urandom_range(0, NUM_SPR - 1));
        cx = (m_act_x[sp] + int'($urandom_range(0, 47)) - 8) & 2047;
        cy = (m_act_y[sp] + int'($urandom_range(0, 47)) - 8) & 2047;
      end
      w = ($urandom_range(0, 7) == 0);
      a = '0; d = '0;
      if (w) begin
        kind = int'($urandom_range(0, 9));
        if (kind < 4) begin
          a = 14'($urandom_range(0, 8191));
          d = 32'(pal());
        end else begin
          a = reg_addr(int'($urandom_range(0, 7)), (kind < 9) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 7)));
          d = (a[2:0] == 3'd4) ? 32'(pal()) : (a[2:0] == 3'd3) ? 32'($urandom_range(0, 3) == 0) : $urandom;
        end
      end
      cyc(cx, cy, w, a, d, 1'b0);
    end

    phase = "reset_mid";
    wr(reg_addr(0, 3), 32'd0);
    frame(1'b1);
    for (int xx = 96; xx <= 135; xx++) cyc(xx, 60, 1'b0, 14'd0, 32'd0, xx == 110);
    frame(1'b1);
    frame(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
